// File: rtl/keypad_signed_alu.sv
// Keypad calculator core: builds two signed decimal operands from key events
// and presents their sum or difference in sign-magnitude form.
module keypad_signed_alu #(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned W          = 7,
  parameter logic [7:0]  KEY_ON_OFF = 8'd18,
  parameter logic [7:0]  KEY_DEF_A  = 8'd15,
  parameter logic [7:0]  KEY_DEF_B  = 8'd19,
  parameter logic [7:0]  KEY_CLEAR  = 8'd16,
  parameter logic [7:0]  KEY_SIGN   = 8'd12,
  parameter logic [7:0]  KEY_SUM    = 8'd26,
  parameter logic [7:0]  KEY_MINUS  = 8'd30
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [7:0]   data,
  input  logic         validate,
  output logic [W-1:0] out_A,
  output logic [W-1:0] out_B,
  output logic         signalA,
  output logic         signalB,
  output logic [W:0]   value,
  output logic         signalR,
  output logic         result_valid,
  output logic         isOn,
  output logic         blank,
  output logic [1:0]   state
);

  localparam int unsigned CW = (DIGITS < 1) ? 1 : $clog2(DIGITS + 1);
  localparam int unsigned RW = W + 2;
  localparam int unsigned VW = W + 1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_EDIT_A = 2'd1,
    ST_EDIT_B = 2'd2
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [1:0]    r_fill;
  state_t        r_state;
  logic          r_on;
  logic          r_blank;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sa;
  logic          r_sb;
  logic [CW-1:0] r_cnt_a;
  logic [CW-1:0] r_cnt_b;
  logic          r_op;
  logic          r_pend;
  logic [VW-1:0] r_value;
  logic          r_sign_r;
  logic          r_valid;

  logic                 w_key;
  logic                 w_is_digit;
  logic                 w_sel_b;
  logic [CW-1:0]        w_cnt_sel;
  logic                 w_room;
  logic [W-1:0]         w_cur;
  logic [W-1:0]         w_acc;
  logic signed [RW-1:0] w_sa;
  logic signed [RW-1:0] w_sb;
  logic signed [RW-1:0] w_r;
  logic [VW-1:0]        w_abs;

  // Synchronizer and falling-edge detector; r_fill keeps the reset value of
  // the sync flops from being mistaken for a real high level of validate.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= validate;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      r_prev  <= r_fill[1] & r_sync2;
    end
  end

  assign w_key      = r_prev & ~r_sync2;
  assign w_is_digit = (data < 8'd10);
  assign w_sel_b    = (r_state == ST_EDIT_B);
  assign w_cnt_sel  = w_sel_b ? r_cnt_b : r_cnt_a;
  assign w_room     = (w_cnt_sel < CW'(DIGITS));
  assign w_cur      = w_sel_b ? r_b : r_a;
  assign w_acc      = w_cur * W'(10) + W'(data[3:0]);

  // Control FSM and operand registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_on    <= 1'b0;
      r_blank <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_op    <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      if (w_key) begin
        if (r_state == ST_OFF) begin
          if (data == KEY_ON_OFF) begin
            r_on    <= 1'b1;
            r_blank <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_op    <= 1'b0;
            r_state <= ST_EDIT_A;
            r_pend  <= 1'b1;
          end
        end else if (data == KEY_ON_OFF) begin
          r_on    <= 1'b0;
          r_blank <= 1'b1;
          r_a     <= '0;
          r_b     <= '0;
          r_sa    <= 1'b0;
          r_sb    <= 1'b0;
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          r_op    <= 1'b0;
          r_state <= ST_OFF;
          r_pend  <= 1'b1;
        end else if (data == KEY_DEF_A) begin
          r_a     <= '0;
          r_sa    <= 1'b0;
          r_cnt_a <= '0;
          r_state <= ST_EDIT_A;
          r_pend  <= 1'b1;
        end else if (data == KEY_DEF_B) begin
          r_b     <= '0;
          r_sb    <= 1'b0;
          r_cnt_b <= '0;
          r_state <= ST_EDIT_B;
          r_pend  <= 1'b1;
        end else if (w_is_digit) begin
          // Digits past the limit are dropped silently (no result strobe)
          if (w_room) begin
            if (w_sel_b) begin
              r_b     <= w_acc;
              r_cnt_b <= r_cnt_b + CW'(1);
            end else begin
              r_a     <= w_acc;
              r_cnt_a <= r_cnt_a + CW'(1);
            end
            r_pend <= 1'b1;
          end
        end else if (data == KEY_SIGN) begin
          if (w_sel_b) r_sb <= ~r_sb;
          else         r_sa <= ~r_sa;
          r_pend <= 1'b1;
        end else if (data == KEY_SUM) begin
          r_op   <= 1'b0;
          r_pend <= 1'b1;
        end else if (data == KEY_MINUS) begin
          r_op   <= 1'b1;
          r_pend <= 1'b1;
        end else if (data == KEY_CLEAR) begin
          r_a     <= '0;
          r_b     <= '0;
          r_sa    <= 1'b0;
          r_sb    <= 1'b0;
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          r_op    <= 1'b0;
          r_state <= ST_EDIT_A;
          r_pend  <= 1'b1;
        end
      end
    end
  end

  // Signed arithmetic; a zero result has its sign bit clear, so no negative zero
  assign w_sa  = r_sa ? -$signed(RW'(r_a)) : $signed(RW'(r_a));
  assign w_sb  = r_sb ? -$signed(RW'(r_b)) : $signed(RW'(r_b));
  assign w_r   = r_op ? (w_sa - w_sb) : (w_sa + w_sb);
  assign w_abs = w_r[RW-1] ? VW'(-w_r) : VW'(w_r);

  // Result stage, one cycle behind the operand registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_value  <= '0;
      r_sign_r <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= r_pend;
      if (r_pend) begin
        r_value  <= w_abs;
        r_sign_r <= w_r[RW-1];
      end
    end
  end

  assign out_A        = r_a;
  assign out_B        = r_b;
  assign signalA      = r_sa;
  assign signalB      = r_sb;
  assign value        = r_value;
  assign signalR      = r_sign_r;
  assign result_valid = r_valid;
  assign isOn         = r_on;
  assign blank        = r_blank;
  assign state        = r_state;

endmodule

// File: tb/tb_keypad_signed_alu.sv
// Self-checking bench for keypad_signed_alu: directed scenarios plus random
// key sequences compared against an integer reference model.
module tb_keypad_signed_alu;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 7;

  logic         CLOCK_50;
  logic         reset;
  logic [7:0]   data;
  logic         validate;
  logic [W-1:0] out_A;
  logic [W-1:0] out_B;
  logic         signalA;
  logic         signalB;
  logic [W:0]   value;
  logic         signalR;
  logic         result_valid;
  logic         isOn;
  logic         blank;
  logic [1:0]   state;

  keypad_signed_alu #(.DIGITS(DIGITS), .W(W)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .data        (data),
    .validate    (validate),
    .out_A       (out_A),
    .out_B       (out_B),
    .signalA     (signalA),
    .signalB     (signalB),
    .value       (value),
    .signalR     (signalR),
    .result_valid(result_valid),
    .isOn        (isOn),
    .blank       (blank),
    .state       (state)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int fall_cyc = 0;
  int rv_cnt = 0;
  int last_lat = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (result_valid) begin
      rv_cnt   = rv_cnt + 1;
      last_lat = cyc - fall_cyc;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk = n_chk + 1;
    if (obs == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: plain integers following the calculator's key rules
  int m_a, m_b, m_ca, m_cb, m_st;
  bit m_sa, m_sb, m_op, m_on;

  task automatic model_clear_ops();
    m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
    m_sa = 0; m_sb = 0; m_op = 0;
  endtask

  task automatic model_reset();
    model_clear_ops();
    m_on = 0;
    m_st = 0;
  endtask

  task automatic model_key(input int k, output bit acc);
    acc = 0;
    if (m_st == 0) begin
      if (k == 18) begin m_on = 1; model_clear_ops(); m_st = 1; acc = 1; end
    end else if (k == 18) begin
      m_on = 0; model_clear_ops(); m_st = 0; acc = 1;
    end else if (k == 15) begin
      m_st = 1; m_a = 0; m_sa = 0; m_ca = 0; acc = 1;
    end else if (k == 19) begin
      m_st = 2; m_b = 0; m_sb = 0; m_cb = 0; acc = 1;
    end else if (k < 10) begin
      if (m_st == 1 && m_ca < DIGITS) begin m_a = m_a * 10 + k; m_ca++; acc = 1; end
      if (m_st == 2 && m_cb < DIGITS) begin m_b = m_b * 10 + k; m_cb++; acc = 1; end
    end else if (k == 12) begin
      if (m_st == 1) m_sa = !m_sa; else m_sb = !m_sb;
      acc = 1;
    end else if (k == 26) begin
      m_op = 0; acc = 1;
    end else if (k == 30) begin
      m_op = 1; acc = 1;
    end else if (k == 16) begin
      model_clear_ops(); m_st = 1; acc = 1;
    end
  endtask

  function automatic int model_result();
    int x, y;
    x = m_sa ? -m_a : m_a;
    y = m_sb ? -m_b : m_b;
    return m_op ? (x - y) : (x + y);
  endfunction

  task automatic check_all(input string tag);
    int r;
    r = model_result();
    check_eq({tag, ".state"},   int'(state),   m_st);
    check_eq({tag, ".isOn"},    int'(isOn),    int'(m_on));
    check_eq({tag, ".blank"},   int'(blank),   int'(!m_on));
    check_eq({tag, ".out_A"},   int'(out_A),   m_a);
    check_eq({tag, ".out_B"},   int'(out_B),   m_b);
    check_eq({tag, ".signalA"}, int'(signalA), int'(m_sa));
    check_eq({tag, ".signalB"}, int'(signalB), int'(m_sb));
    check_eq({tag, ".value"},   int'(value),   (r < 0) ? -r : r);
    check_eq({tag, ".signalR"}, int'(signalR), (r < 0) ? 1 : 0);
  endtask

  // One key: validate low for low_cyc clocks, then high long enough to settle
  task automatic press(input string tag, input int k, input int low_cyc);
    bit acc;
    int rv0;
    rv0 = rv_cnt;
    @(negedge CLOCK_50);
    data     = 8'(k);
    validate = 1'b0;
    fall_cyc = cyc;
    repeat (low_cyc) @(negedge CLOCK_50);
    validate = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    model_key(k, acc);
    check_eq({tag, ".rv_pulses"}, rv_cnt - rv0, int'(acc));
    check_all(tag);
  endtask

  function automatic int rand_key();
    int r;
    int specials[7];
    specials = '{15, 19, 16, 12, 26, 30, 18};
    r = int'($urandom_range(0, 99));
    if (r < 45) return int'($urandom_range(0, 9));
    else if (r < 93) return specials[$urandom_range(0, 6)];
    else return int'($urandom_range(40, 255));
  endfunction

  initial begin
    int rv0;
    reset    = 1'b1;
    validate = 1'b1;
    data     = 8'd0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check_eq("reset.rv_idle", rv_cnt, 0);
    check_eq("reset.result_valid", int'(result_valid), 0);
    check_all("reset");

    press("power_on", 18, 3);
    check_eq("power_on.latency_4to5", (last_lat >= 4 && last_lat <= 5) ? 1 : 0, 1);

    rv0 = rv_cnt;
    press("dig4", 4, 2);
    press("dig7", 7, 3);
    press("dig3_ignored", 3, 2);
    check_eq("digits.out_A", int'(out_A), 47);
    check_eq("digits.rv_total", rv_cnt - rv0, 2);
    check_eq("digits.value", int'(value), 47);

    press("clr1", 16, 2);
    press("a2", 2, 2);
    press("a5", 5, 2);
    press("signA", 12, 2);
    press("defB", 19, 2);
    press("b9", 9, 2);
    press("sum", 26, 2);
    check_eq("sum.value", int'(value), 16);
    check_eq("sum.signalR", int'(signalR), 1);
    press("minus", 30, 2);
    check_eq("minus.value", int'(value), 34);
    check_eq("minus.signalR", int'(signalR), 1);

    press("clr2", 16, 2);
    press("a1", 1, 2);
    press("a2b", 2, 2);
    press("signA2", 12, 2);
    press("defB2", 19, 2);
    press("b1", 1, 2);
    press("b2", 2, 2);
    press("sum2", 26, 2);
    check_eq("zero.value", int'(value), 0);
    check_eq("zero.signalR", int'(signalR), 0);

    press("clr3", 16, 2);
    press("a9", 9, 2);
    press("a9b", 9, 2);
    press("defB3", 19, 2);
    press("b9a", 9, 2);
    press("b9b", 9, 2);
    press("signB", 12, 2);
    press("minus2", 30, 2);
    check_eq("max.value", int'(value), 198);
    check_eq("max.signalR", int'(signalR), 0);

    press("clr4", 16, 2);
    check_eq("clear.state", int'(state), 1);
    press("off", 18, 2);
    check_eq("off.blank", int'(blank), 1);
    press("off_digit", 5, 2);

    // Reset in the key-event cycle while validate stays low
    press("on2", 18, 2);
    press("c3", 3, 2);
    rv0 = rv_cnt;
    @(negedge CLOCK_50);
    data     = 8'd7;
    validate = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    repeat (6) @(negedge CLOCK_50);
    check_eq("rst_mid.rv_low", rv_cnt - rv0, 0);
    check_all("rst_mid.low");
    validate = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check_eq("rst_mid.rv_high", rv_cnt - rv0, 0);
    check_all("rst_mid.high");
    press("rst_mid.on", 18, 2);

    for (int i = 0; i < 300; i++) begin
      press("rand", rand_key(), int'($urandom_range(2, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_signed_alu.md
# keypad_signed_alu

Parametrised successor to the two-operand keypad calculator. It accepts decoded keypad codes qualified by a falling edge on `validate`, builds two signed decimal operands of up to `DIGITS` digits each, and computes their sum or difference in sign-magnitude form for the BCD display stage. Unlike the previous block, it is fully synchronous to `CLOCK_50`. It adds an explicit reset, a selectable operation, a digit-count limit and a result-valid strobe.

## Interface
- `DIGITS`, 2: maximum decimal digits per operand.
- `W`, 7: operand magnitude width. Must satisfy 10^DIGITS-1 < 2^W.
- `KEY_ON_OFF`, 8'd18: power toggle.
- `KEY_DEF_A`, 8'd15: select operand A and zero it.
- `KEY_DEF_B`, 8'd19: select operand B and zero it.
- `KEY_CLEAR`, 8'd16: clear all.
- `KEY_SIGN`, 8'd12: toggle the sign of the selected operand.
- `KEY_SUM`, 8'd26: select A+B.
- `KEY_MINUS`, 8'd30: select A−B.
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  8  key code; sampled in the key-event cycle.
- `validate`  in  1  key strobe from the keypad, asynchronous, idle high; a key is the 1→0 transition.
- `out_A`, `out_B`  out  W  operand magnitudes.
- `signalA`, `signalB`  out  1  operand signs (1 = negative).
- `value`  out  W+1  result magnitude.
- `signalR`  out  1  result sign.
- `result_valid`  out  1  one-cycle pulse when `value`/`signalR` update.
- `isOn`  out  1  calculator powered.
- `blank`  out  1  display blanking; equals ~isOn.
- `state`  out  2  0 = OFF, 1 = EDIT_A, 2 = EDIT_B.

## Operation
- **Key-event detection**
  - `validate` passes through a 2-flop synchronizer, then a falling-edge detector; both synchronizer flops reset to 1.
  - A key event is one cycle with the synchronized value 1 in the previous cycle and 0 in the current cycle.
- **Reset values:** state OFF, isOn 0, all operands 0, signs 0, digit counters 0, op = SUM, value 0, signalR 0, result_valid 0.
- **OFF state:** every key except `KEY_ON_OFF` is ignored. `KEY_ON_OFF` sets isOn=1, clears operands, signs, counters and op, and moves to EDIT_A.
- **EDIT_A / EDIT_B**
  - `KEY_ON_OFF`: isOn=0, clear everything, go to OFF.
  - `KEY_DEF_A` / `KEY_DEF_B`: go to EDIT_A / EDIT_B; zero that operand's magnitude, sign and digit counter.
  - Digit 0–9 while the selected counter is below DIGITS: operand ← operand*10 + digit; counter+1.
  - Digit 0–9 when the counter equals DIGITS: ignored.
  - Leading zeros count as digits.
  - `KEY_SIGN`: toggles the selected operand's sign; allowed on zero.
  - `KEY_SUM` / `KEY_MINUS`: set op; state unchanged.
  - `KEY_CLEAR`: clear both operands, signs, counters and op; go to EDIT_A.
  - Any other code: no effect, no result_valid.
- **Arithmetic**
  - sA = signalA ? −out_A : out_A; sB likewise.
  - r = sA + sB for SUM, sA − sB for MINUS, computed at W+2 bits signed.
  - value = |r|; signalR = r<0.
  - r = 0 forces signalR = 0 (no negative zero).
- **OFF outputs:** out_A, out_B and value read 0.

## Timing
- **Key event in cycle k**
  - Operand, sign, op and state registers are visible at k+1.
  - `value`/`signalR` are updated at k+2, with result_valid high for exactly cycle k+2.
- **End-to-end latency:** from `validate` falling to result_valid is 4–5 clocks.
- `validate` must stay low ≥2 clocks and high ≥2 clocks between keys. Shorter pulses may be lost; they must never be double-counted.
- At most one key event per `validate` low phase.
- `data` must be stable from the falling edge of `validate` until the event cycle.
- **Reset dominance:** reset during any cycle overrides a simultaneous key event, and any pending result_valid is dropped.
- **Reset while `validate` is held low:** no event until `validate` returns high and falls again.
- A result_valid pulse follows every accepted key, including ones that do not change the result. It does not follow ignored digits or ignored codes.

## Test plan
- **Reset, then power on:** reset, then ON_OFF → state=1, isOn=1, blank=0, out_A=0, value=0, signalR=0.
- **Digit entry and limit:** ON, keys 4,7,3 → out_A=47, third digit ignored, exactly 2 result_valid pulses, value=47.
- **Signed add:** A=25 with SIGN (−25), DEF_B, 9, SUM → value=16, signalR=1. Then MINUS → −25−9: value=34, signalR=1.
- **Zero result:** A=−12, B=12 with SUM → value=0, signalR=0. Also verify the maximum: A=99, B=−99, MINUS → value=198, signalR=0.
- **Clear and off:** CLEAR → all zero, state=1. ON_OFF → state=0, blank=1. Digit 5 while off → no change, no result_valid.
- **Reset mid-entry:** assert reset in the same cycle as a key event, with `validate` held low → outputs at reset values. No event occurs until the next 1→0 transition of `validate`.
